ym_dbg_capture: RTL and testbench
=================================

YM_DBG_CAPTURE -- requirements
Module: ym_dbg_capture

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: bits per debug word.
REQ-002 SHALL have parameter WORDS, default 4: words per frame (range 1..16).
REQ-003 SHALL have port MCLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port sh, input, 1 bit: shift strobe; one serial bit per MCLK cycle with sh=1.
REQ-006 SHALL have port load, input, 1 bit: frame start; same cycle in which the transmitting chain parallel-loads.
REQ-007 SHALL have port sin, input, 1 bit: serial data from the chain tail, LSB of each word first.
REQ-008 SHALL have port out_data, output, DATA_WIDTH bits: captured word.
REQ-009 SHALL have port out_idx, output, 4 bits: word position in frame, 0 = first word shifted out.
REQ-010 SHALL have port out_valid, output, 1 bit: out_data/out_idx hold a buffered word.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts; transfer when out_valid & out_ready.
REQ-012 SHALL have port frame_done, output, 1 bit: one-cycle pulse after the last word of a frame is captured.
REQ-013 SHALL have port ovf, output, 1 bit: sticky overflow flag.
REQ-014 SHALL have port ovf_clr, input, 1 bit: clears ovf.

Function
REQ-015 SHALL implement a two-state FSM: IDLE, RUN.
REQ-016 IDLE: sh and sin ignored; load=1 -> RUN with bit_cnt=0, word_cnt=0.
REQ-017 The load cycle SHALL NOT sample sin; sampling starts at the first sh=1 cycle after load.
REQ-018 RUN, sh=1: sin SHALL enter the shift register MSB, register shifts right; bit_cnt increments.
REQ-019 On the DATA_WIDTH-th sampled bit, {word_cnt, word} SHALL be pushed to the output buffer, bit_cnt -> 0, word_cnt increments.
REQ-020 When word_cnt reaches WORDS: FSM -> IDLE, frame_done pulses in the following cycle.
REQ-021 Push SHALL make out_valid=1 in the cycle after the last bit's sampling edge (latency 1).
REQ-022 Output buffer SHALL be a 2-entry FIFO, in order; out_* show the head entry.
REQ-023 Push while full without simultaneous pop: new word dropped, ovf set next cycle.
REQ-024 Push and pop in the same cycle while full SHALL both succeed, no overflow.
REQ-025 load=1 in RUN SHALL discard the partial word, restart counters at 0, and stay in RUN; buffered words are kept.
REQ-026 load and a completing shift in the same cycle: load wins; the partial word is discarded.
REQ-027 ovf_clr and an overflow event in the same cycle: ovf stays set.
REQ-028 sh=0 in RUN SHALL hold all counters and the shift register.

Reset
REQ-029 reset=0 SHALL asynchronously force: FSM IDLE, counters 0, shift register 0, FIFO empty.
REQ-030 While reset=0: out_valid=0, out_data=0, out_idx=0, frame_done=0, ovf=0.
REQ-031 Reset mid-frame SHALL drop the partial frame; capture resumes only after the next load.

Structure
REQ-032 A shared package SHALL hold the FSM state enum and the out_idx width constant (4).
REQ-033 The 2-entry FIFO SHALL be one sub-module, ym_dbg_fifo2, parameterised by entry width.
REQ-034 No internal clock gating; sh, load and ovf_clr are synchronous enables only.

Verification
REQ-035 DATA_WIDTH=8, WORDS=4, out_ready=1; load, then 32 sh cycles carrying 0x11,0x22,0x33,0x44 LSB-first -> four transfers, idx 0..3, data 0x11..0x44 in order; frame_done one cycle after the 4th word.
REQ-036 out_ready=0 for the same frame -> words 0x11 and 0x22 buffered; 3rd push sets ovf; after out_ready=1, reads return 0x11 then 0x22 only.
REQ-037 load asserted after 5 bits of word 1 -> partial word dropped; the next 8 bits 0xA5 appear as idx 0.
REQ-038 Full FIFO with out_ready=1 in the push cycle -> no ovf; data order preserved.
REQ-039 reset pulled low after 20 bits of a frame -> all outputs 0 at once; sh bits without load -> no out_valid.
REQ-040 Random gaps (sh=0) between bits -> captured data identical to the gap-free case.

Source files
------------

// File: rtl/ym_dbg_capture_pkg.sv
// ---------------------------------------------------------------------------
// ym_dbg_capture_pkg
// Shared definitions for the debug-chain capture block.
//   IDX_W        : width of the word-position field carried with each word
//   cap_state_t  : capture FSM state (IDLE waits for load, RUN samples bits)
// ---------------------------------------------------------------------------
package ym_dbg_capture_pkg;

  localparam int IDX_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } cap_state_t;

endpackage

// File: rtl/ym_dbg_fifo2.sv
// ---------------------------------------------------------------------------
// ym_dbg_fifo2
// Two-entry in-order FIFO used as the output buffer of the capture block.
// Ports:
//   MCLK      : clock, rising edge
//   reset     : asynchronous active-low reset, empties the FIFO
//   push      : write request for push_data
//   push_data : entry to write
//   pop       : read request; the head entry is removed
//   head_data : current head entry (oldest)
//   not_empty : at least one entry is held
//   full      : both entries are held
// A push while full is accepted only when a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module ym_dbg_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             MCLK,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             not_empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             do_push;
  logic             do_pop;

  // Freeing the head slot in the same cycle makes room for a push into a
  // full buffer, so push acceptance depends on the pop decision.
  always_comb begin
    do_pop  = pop & not_empty;
    do_push = push & (~full | do_pop);
  end

  always_ff @(posedge MCLK or negedge reset) begin
    if (!reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    head_data = mem[rd_ptr];
    not_empty = (count != 2'd0);
    full      = (count == 2'd2);
  end

endmodule

// File: rtl/ym_dbg_capture.sv
// ---------------------------------------------------------------------------
// ym_dbg_capture
// Deserialises frames of WORDS debug words, each DATA_WIDTH bits, shifted
// LSB-first out of a scan chain, and presents them through a 2-entry
// valid/ready output buffer.
// Ports:
//   MCLK       : clock, all state changes on rising edge
//   reset      : asynchronous active-low reset
//   sh         : shift strobe, one serial bit per cycle with sh=1
//   load       : frame start (chain parallel-load cycle, no bit sampled)
//   sin        : serial data from the chain tail
//   out_data   : captured word at the buffer head
//   out_idx    : position of that word in its frame (0 = first out)
//   out_valid  : buffer head holds a word
//   out_ready  : consumer accepts the head word
//   frame_done : one-cycle pulse after the last word of a frame is captured
//   ovf        : sticky flag, a word was dropped because the buffer was full
//   ovf_clr    : clears ovf (an overflow in the same cycle takes priority)
// ---------------------------------------------------------------------------
module ym_dbg_capture
  import ym_dbg_capture_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int WORDS      = 4
) (
  input  logic                  MCLK,
  input  logic                  reset,
  input  logic                  sh,
  input  logic                  load,
  input  logic                  sin,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [IDX_W-1:0]      out_idx,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_done,
  output logic                  ovf,
  input  logic                  ovf_clr
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int ENT_W = IDX_W + DATA_WIDTH;

  cap_state_t            state;
  cap_state_t            next_state;
  logic [BIT_W-1:0]      bit_cnt;
  logic [IDX_W-1:0]      word_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shift_next;
  logic                  last_bit;
  logic                  last_word;
  logic                  shift_en;
  logic                  push;
  logic                  frame_end;
  logic                  pop;
  logic                  fifo_full;
  logic                  ovf_evt;
  logic [ENT_W-1:0]      head;

  // Bits arrive LSB first, so each new bit enters at the MSB and the
  // register shifts right; after DATA_WIDTH bits the first bit is at bit 0.
  always_comb begin
    shift_next = DATA_WIDTH'({sin, shreg} >> 1);
    last_bit   = (bit_cnt == BIT_W'(DATA_WIDTH - 1));
    last_word  = (word_cnt == IDX_W'(WORDS - 1));
  end

  always_ff @(posedge MCLK or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // load always (re)starts a frame, so it is checked before the frame end.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (load) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (!load && sh && last_bit && last_word) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // load suppresses sampling, which also makes it win over a completing shift.
  always_comb begin
    shift_en  = (state == RUN) && sh && !load;
    push      = shift_en && last_bit;
    frame_end = push && last_word;
  end

  always_ff @(posedge MCLK or negedge reset) begin
    if (!reset) begin
      bit_cnt  <= '0;
      word_cnt <= '0;
      shreg    <= '0;
    end else if (load) begin
      bit_cnt  <= '0;
      word_cnt <= '0;
      shreg    <= '0;
    end else if (shift_en) begin
      shreg <= shift_next;
      if (last_bit) begin
        bit_cnt  <= '0;
        word_cnt <= last_word ? '0 : word_cnt + 1'b1;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    pop     = out_valid & out_ready;
    ovf_evt = push & fifo_full & ~pop;
  end

  ym_dbg_fifo2 #(
    .WIDTH(ENT_W)
  ) u_fifo (
    .MCLK      (MCLK),
    .reset     (reset),
    .push      (push),
    .push_data ({word_cnt, shift_next}),
    .pop       (pop),
    .head_data (head),
    .not_empty (out_valid),
    .full      (fifo_full)
  );

  always_comb begin
    out_idx  = head[ENT_W-1:DATA_WIDTH];
    out_data = head[DATA_WIDTH-1:0];
  end

  // An overflow in the same cycle as ovf_clr keeps the flag set.
  always_ff @(posedge MCLK or negedge reset) begin
    if (!reset) begin
      frame_done <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (ovf_evt) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ym_dbg_capture.sv
// ---------------------------------------------------------------------------
// tb_ym_dbg_capture
// Bench for ym_dbg_capture (DATA_WIDTH=8, WORDS=4). A frame-level model
// (bit accumulator + queue of buffered words) predicts the outputs every
// cycle; table rows and hand sequences add explicit expectations.
// ---------------------------------------------------------------------------
module tb_ym_dbg_capture;

  localparam int DW = 8;
  localparam int NW = 4;

  typedef enum int {RDY_ALWAYS, RDY_NEVER, RDY_LATE} rdy_mode_t;

  typedef struct packed {
    logic [3:0] idx;
    logic [7:0] data;
  } ent_t;

  typedef struct {
    logic [31:0] words;
    bit          gaps;
    rdy_mode_t   mode;
    int          exp_n;
    logic [31:0] exp_data;
    bit          exp_ovf;
  } vec_t;

  logic          MCLK;
  logic          reset;
  logic          sh;
  logic          load;
  logic          sin;
  logic [DW-1:0] out_data;
  logic [3:0]    out_idx;
  logic          out_valid;
  logic          out_ready;
  logic          frame_done;
  logic          ovf;
  logic          ovf_clr;

  int total;
  int bad;

  logic cur_ready;
  logic cur_clr;
  ent_t xfer_q[$];

  // reference model state
  bit         m_run;
  int         m_nbits;
  int         m_widx;
  logic [7:0] m_acc;
  ent_t       mq[$];
  bit         m_ovf;
  bit         m_fd;

  ym_dbg_capture #(
    .DATA_WIDTH(DW),
    .WORDS     (NW)
  ) dut (
    .MCLK      (MCLK),
    .reset     (reset),
    .sh        (sh),
    .load      (load),
    .sin       (sin),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_done(frame_done),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  // free-running clock
  initial begin
    MCLK = 1'b0;
    forever #5 MCLK = ~MCLK;
  end

  // watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic modelReset();
    m_run   = 0;
    m_nbits = 0;
    m_widx  = 0;
    m_acc   = '0;
    mq.delete();
    m_ovf   = 0;
    m_fd    = 0;
  endtask

  // one clock edge of the frame-level model, using the inputs held this cycle
  task automatic modelStep();
    bit   pop;
    bit   have_new;
    ent_t nw;
    pop      = (mq.size() > 0) && out_ready;
    have_new = 0;
    nw       = '0;
    m_fd     = 0;
    if (load) begin
      m_run   = 1;
      m_nbits = 0;
      m_widx  = 0;
      m_acc   = '0;
    end else if (m_run && sh) begin
      m_acc = m_acc | (8'(sin) << m_nbits);
      m_nbits++;
      if (m_nbits == DW) begin
        have_new = 1;
        nw.idx   = 4'(m_widx);
        nw.data  = m_acc;
        m_nbits  = 0;
        m_acc    = '0;
        m_widx++;
        if (m_widx == NW) begin
          m_run  = 0;
          m_widx = 0;
          m_fd   = 1;
        end
      end
    end
    if (pop) void'(mq.pop_front());
    if (have_new && mq.size() >= 2) m_ovf = 1;
    else if (ovf_clr) m_ovf = 0;
    if (have_new && mq.size() < 2) mq.push_back(nw);
  endtask

  task automatic checkOutput();
    if (reset) begin
      check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
        check("out_data", 32'(out_data), 32'(mq[0].data));
        check("out_idx", 32'(out_idx), 32'(mq[0].idx));
      end
      check("frame_done", 32'(frame_done), 32'(m_fd));
      check("ovf", 32'(ovf), 32'(m_ovf));
    end
  endtask

  // drive one cycle of inputs (called at a falling edge), record any
  // transfer, advance the model at the rising edge, then compare
  task automatic applyStimulus(input logic s, input logic l, input logic d);
    sh        = s;
    load      = l;
    sin       = d;
    out_ready = cur_ready;
    ovf_clr   = cur_clr;
    #1;
    if (reset && out_valid && out_ready) xfer_q.push_back({out_idx, out_data});
    @(posedge MCLK);
    modelStep();
    @(negedge MCLK);
    checkOutput();
  endtask

  task automatic sendFrame(input vec_t v);
    cur_clr = 0;
    xfer_q.delete();
    cur_ready = (v.mode == RDY_ALWAYS);
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int n = 0; n < DW * NW; n++) begin
      case (v.mode)
        RDY_ALWAYS: cur_ready = 1'b1;
        RDY_NEVER:  cur_ready = 1'b0;
        default:    cur_ready = (n >= 23);
      endcase
      if (v.gaps) repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 1'b0, 1'($urandom));
      applyStimulus(1'b1, 1'b0, v.words[n]);
    end
    check("frame_done_pulse", 32'(frame_done), 32'd1);
    cur_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    check("frame_done_end", 32'(frame_done), 32'd0);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
    check("xfer_count", 32'(xfer_q.size()), 32'(v.exp_n));
    for (int i = 0; i < v.exp_n && i < xfer_q.size(); i++) begin
      check("xfer_idx", 32'(xfer_q[i].idx), 32'(i));
      check("xfer_data", 32'(xfer_q[i].data), 32'(v.exp_data[i*8 +: 8]));
    end
    check("ovf_after_frame", 32'(ovf), 32'(v.exp_ovf));
    cur_clr = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    cur_clr = 1'b0;
    check("ovf_cleared", 32'(ovf), 32'd0);
  endtask

  vec_t       vecs[6];
  logic [7:0] pat;

  initial begin
    total = 0;
    bad   = 0;
    vecs[0] = '{32'h44332211, 1'b0, RDY_ALWAYS, 4, 32'h44332211, 1'b0};
    vecs[1] = '{32'h44332211, 1'b0, RDY_NEVER,  2, 32'h00002211, 1'b1};
    vecs[2] = '{32'h44332211, 1'b1, RDY_ALWAYS, 4, 32'h44332211, 1'b0};
    vecs[3] = '{32'h44332211, 1'b0, RDY_LATE,   4, 32'h44332211, 1'b0};
    vecs[4] = '{32'h5AC3F00F, 1'b0, RDY_ALWAYS, 4, 32'h5AC3F00F, 1'b0};
    vecs[5] = '{32'h5AC3F00F, 1'b1, RDY_ALWAYS, 4, 32'h5AC3F00F, 1'b0};

    reset     = 1'b0;
    sh        = 1'b0;
    load      = 1'b0;
    sin       = 1'b0;
    out_ready = 1'b1;
    ovf_clr   = 1'b0;
    cur_ready = 1'b1;
    cur_clr   = 1'b0;
    modelReset();
    repeat (2) @(negedge MCLK);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_idx", 32'(out_idx), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);

    // table-driven frames
    for (int r = 0; r < 6; r++) begin
      $display("[TB] frame row %0d", r);
      sendFrame(vecs[r]);
    end

    // reload after 5 bits: partial word discarded, next byte is idx 0
    cur_ready = 1'b1;
    xfer_q.delete();
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    pat = 8'hA5;
    for (int b = 0; b < DW; b++) applyStimulus(1'b1, 1'b0, pat[b]);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
    check("reload_count", 32'(xfer_q.size()), 32'd1);
    if (xfer_q.size() > 0) begin
      check("reload_idx", 32'(xfer_q[0].idx), 32'd0);
      check("reload_data", 32'(xfer_q[0].data), 32'hA5);
    end

    // reset mid-frame after 20 bits, then bits without load
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int b = 0; b < 20; b++) applyStimulus(1'b1, 1'b0, 1'($urandom));
    #2;
    reset = 1'b0;
    modelReset();
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_data", 32'(out_data), 32'd0);
    check("midrst_idx", 32'(out_idx), 32'd0);
    check("midrst_frame_done", 32'(frame_done), 32'd0);
    check("midrst_ovf", 32'(ovf), 32'd0);
    @(negedge MCLK);
    reset = 1'b1;
    for (int b = 0; b < 16; b++) applyStimulus(1'b1, 1'b0, 1'($urandom));
    check("no_load_valid", 32'(out_valid), 32'd0);

    // random traffic against the model
    for (int i = 0; i < 2500; i++) begin
      cur_ready = ($urandom_range(0, 3) != 0);
      cur_clr   = ($urandom_range(0, 9) == 0);
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 59) == 0), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
